// File: rtl/seg7_count_monitor.sv
// Seven-segment display bus monitor: debounces {sel,co,seg}, decodes the accepted
// pattern back to a 0..15 count and checks that accepted values follow the up-count.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   HUNT  | no trusted reference value; next legal accept is taken as-is
//   TRACK | reference held in value; each legal accept must be value+1 mod 16
module seg7_count_monitor #(
    parameter int STABLE_CYC = 3,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             cr,
    input  logic [6:0]       seg,
    input  logic             co,
    input  logic             sel,
    output logic [3:0]       value,
    output logic             value_vld,
    output logic             illegal,
    output logic             seq_err,
    output logic             locked,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic {HUNT, TRACK} state_t;

    localparam logic [3:0] STAB_MAX = 4'(STABLE_CYC);
    localparam logic [3:0] STAB_ACC = 4'(STABLE_CYC - 1);

    state_t     state, state_nxt;
    logic [8:0] smp, smp_d;
    logic [3:0] stab, stab_nxt;

    logic       smp_sel, smp_co;
    logic [6:0] smp_seg;
    logic       same, accept;

    logic [3:0] digit, dec_val;
    logic       dig_ok, legal;

    logic [3:0]       value_nxt;
    logic             vld_nxt, ill_nxt, seq_nxt, err_inc;
    logic [ERR_W-1:0] err_nxt;

    assign smp_sel = smp[8];
    assign smp_co  = smp[7];
    assign smp_seg = smp[6:0];
    assign same    = (smp == smp_d);

    // stab == STAB_ACC with the pattern still present is the one edge of each
    // stable run where acceptance fires; saturation at STAB_MAX blocks re-fire.
    assign accept  = !smp_sel && same && (stab == STAB_ACC);

    always_comb begin
        stab_nxt = 4'd0;
        if (!smp_sel && same) begin
            stab_nxt = (stab == STAB_MAX) ? stab : stab + 4'd1;
        end
    end

    always_comb begin
        digit  = 4'd0;
        dig_ok = 1'b1;
        case (smp_seg)
            7'b1111110: digit = 4'd0;
            7'b0110000: digit = 4'd1;
            7'b1101101: digit = 4'd2;
            7'b1111001: digit = 4'd3;
            7'b0110011: digit = 4'd4;
            7'b1011011: digit = 4'd5;
            7'b1011111: digit = 4'd6;
            7'b1110000: digit = 4'd7;
            7'b1111111: digit = 4'd8;
            7'b1111011: digit = 4'd9;
            default:    dig_ok = 1'b0;
        endcase
    end

    // With co set only digits 0..5 fit in four bits.
    assign legal   = dig_ok && !(smp_co && (digit > 4'd5));
    assign dec_val = smp_co ? digit + 4'd10 : digit;

    always_comb begin
        state_nxt = state;
        value_nxt = value;
        vld_nxt   = 1'b0;
        ill_nxt   = 1'b0;
        seq_nxt   = 1'b0;
        err_inc   = 1'b0;
        if (accept) begin
            if (!legal) begin
                ill_nxt   = 1'b1;
                err_inc   = 1'b1;
                state_nxt = HUNT;
            end else begin
                value_nxt = dec_val;
                vld_nxt   = 1'b1;
                state_nxt = TRACK;
                if ((state == TRACK) && (dec_val != value + 4'd1)) begin
                    seq_nxt = 1'b1;
                    err_inc = 1'b1;
                end
            end
        end
    end

    assign err_nxt = (err_inc && (err_cnt != '1)) ? err_cnt + ERR_W'(1) : err_cnt;

    always_ff @(posedge clk or posedge cr) begin
        if (cr) begin
            smp       <= '0;
            smp_d     <= '0;
            stab      <= 4'd0;
            state     <= HUNT;
            value     <= 4'd0;
            value_vld <= 1'b0;
            illegal   <= 1'b0;
            seq_err   <= 1'b0;
            err_cnt   <= '0;
        end else begin
            smp       <= {sel, co, seg};
            smp_d     <= smp;
            stab      <= stab_nxt;
            state     <= state_nxt;
            value     <= value_nxt;
            value_vld <= vld_nxt;
            illegal   <= ill_nxt;
            seq_err   <= seq_nxt;
            err_cnt   <= err_nxt;
        end
    end

    assign locked = (state == TRACK);

endmodule
